npu_conv_engine: RTL and testbench
==================================

# npu_conv_engine

Parametrised, memory-mapped convolution engine: the next generation of the NPU memory-port wrapper. A 32-bit SRAM-like slave port (axi2mem compatible, mapped behind the AXI crossbar) loads per-lane weights and either per-lane or broadcast inputs. A control FSM then sequences all K_SIZE×K_SIZE taps through N pipelined signed MAC lanes and exposes busy/done status and per-lane results for readback.

## Interface
- N, 10: number of MAC lanes.
- K_SIZE, 3: kernel edge; KK = K_SIZE*K_SIZE taps per run.
- DATA_WIDTH, 8: signed operand width (≤ 16).
- ACC_WIDTH, 3*DATA_WIDTH: signed accumulator/result width (≤ 32).
- AXI_WIDTH, 32: port data width.
- ADDR_W, 8: word-address width; must satisfy 2^ADDR_W > RBASE+N.
- clk  in  1: single clock, rising edge.
- reset  in  1: asynchronous, active-high reset.
- req_i  in  1: access qualifier; no access when 0.
- wen_i  in  4: byte enables; write when req_i && |wen_i, else read.
- addr_i  in  ADDR_W: word index (byte offset / 4).
- wdata_i  in  AXI_WIDTH: write data; element data in bits [DATA_WIDTH-1:0].
- rdata_o  out  AXI_WIDTH: registered read data.

## Operation
- Word map (one element per word): 0 CTRL (W): bit0 start, bit1 clear, bit2 mode (0 per-lane inputs, 1 broadcast). 1 STATUS (R): bit0 busy, bit1 done, bit2 mode, bits[15:8] tap index. WBASE=16: weights, index lane*KK+tap. IBASE=WBASE+N*KK: per-lane inputs, same indexing. BBASE=IBASE+N*KK: broadcast inputs, index tap. RBASE=BBASE+KK: results, index lane, read-only.
- Reading CTRL returns the stored mode in bit2, all other bits 0. Reading WBASE..RBASE-1 returns the stored element sign-extended. Reading RBASE+i returns result[i] sign-extended. Unmapped addresses read 0.
- Writes to STATUS, the result region, or unmapped addresses are ignored.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on a CTRL write with start=1 and clear=0. This latches mode, sets tap=0, zeroes the accumulators and clears done.
  - RUN issues one tap per cycle to all lanes. Lane i uses a = weight[i][tap] and b = mode ? bcast[tap] : input[i][tap]. RUN→DRAIN after tap KK-1.
  - DRAIN→DONE after one cycle.
  - DONE: copies accumulators into the result registers, sets done, then returns to IDLE.
- Arithmetic: product is a full signed 2*DATA_WIDTH value, sign-extended and added into ACC_WIDTH with two's-complement wrap (no saturation).
- While busy (state ≠ IDLE):
  - Buffer and mode writes are ignored.
  - start is ignored.
  - clear=1 aborts: next state IDLE, accumulators zeroed, done=0, result registers unchanged.
- In IDLE, clear=1 zeroes done and the accumulators. If start=1 and clear=1 are written together, clear wins.
- Result registers hold the previous run's values until the next run reaches DONE.
- done is sticky until the next start or clear.

## Timing
- Reset (async) values: rdata_o 0, all buffers 0, results 0, accumulators 0, state IDLE, done 0, busy 0, mode 0, tap 0.
- Reads: rdata_o is updated at the clock edge after a cycle with req_i=1 and wen_i=0, and holds its value otherwise. Zero wait states, 1-cycle read latency.
- Writes take effect at the sampling edge; data is readable at the following read.
- MAC pipeline: operand select (comb), product register, then accumulate.
- Start sampled at edge E0:
  - busy=1 from E0.
  - Tap t product registers at E(t+1) and accumulates at E(t+2).
  - State is DRAIN at E(KK) and DONE at E(KK+1).
  - At E(KK+2): results valid, done=1, busy=0.
  - With the defaults, done is visible 11 cycles after the start write.
- A STATUS read issued at the cycle of E(KK+2) sees the pre-edge status (busy=1).
- Reset asserted mid-run returns every element to its reset value immediately. There is no partial result.

## Structure
- Package npu_pkg holds:
  - Word-offset constants CTRL_ADDR, STATUS_ADDR, WBASE.
  - Functions computing IBASE, BBASE and RBASE from N and KK.
  - CTRL/STATUS bit-position localparams.
  - The state enum typedef (IDLE, RUN, DRAIN, DONE).
- One sub-module, npu_mac_lane:
  - Ports: clk, reset, clr, en, a, b, acc.
  - Contains the product register and the accumulator.
  - Instantiated N times.
- The top holds the port decode, buffers, FSM, tap counter, result registers and read mux.

## Test plan
- Reset, then read STATUS, CTRL, WBASE and RBASE → all 0. After one idle cycle with req_i=0, rdata_o is unchanged.
- Per-lane mode: lane 0 weights all 1, inputs 1..9; start → done=1 exactly 11 cycles after the start write; RESULT[0]=45, other lanes 0.
- Broadcast mode: lane i weights all i+1, broadcast inputs all 2; start → RESULT[i]=18*(i+1); STATUS bit2=1.
- Signed corner: lane 0 weight −128 and input −128 at all 9 taps → RESULT[0]=147456. Weight 127 with input −128 at all 9 taps → −146304, read back sign-extended.
- During busy:
  - A weight write of 5 is ignored (readback shows the old value).
  - A second start is ignored.
  - clear at cycle 4 → busy=0 next cycle, done=0, RESULT keeps the previous run's values.
- Async reset pulse mid-RUN (between edges) → outputs 0 immediately; a subsequent full run is correct.

Source files
------------

// File: rtl/npu_pkg.sv
// npu_pkg: shared address map, control/status bit positions and FSM state type for the conv engine.
package npu_pkg;
    localparam int CTRL_ADDR   = 0;
    localparam int STATUS_ADDR = 1;
    localparam int WBASE       = 16;
    localparam int CTRL_START  = 0;
    localparam int CTRL_CLEAR  = 1;
    localparam int CTRL_MODE   = 2;
    localparam int ST_BUSY     = 0;
    localparam int ST_DONE     = 1;
    localparam int ST_MODE     = 2;
    localparam int ST_TAP      = 8;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    function automatic int ibase(input int n, input int kk);
        return WBASE + n * kk;
    endfunction
    function automatic int bbase(input int n, input int kk);
        return ibase(n, kk) + n * kk;
    endfunction
    function automatic int rbase(input int n, input int kk);
        return bbase(n, kk) + kk;
    endfunction
endpackage

// File: rtl/npu_mac_lane.sv
// npu_mac_lane: one signed MAC lane, registered product then wrapping accumulate.
module npu_mac_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clr,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [ACC_WIDTH-1:0]  acc
);
    logic signed [2*DATA_WIDTH-1:0] r_prod;
    logic                           r_pv;
    logic signed [ACC_WIDTH-1:0]    r_acc;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prod <= '0;
            r_pv   <= 1'b0;
            r_acc  <= '0;
        end else if (clr) begin
            r_prod <= '0;
            r_pv   <= 1'b0;
            r_acc  <= '0;
        end else begin
            r_pv   <= en;
            r_prod <= a * b;
            if (r_pv) r_acc <= r_acc + ACC_WIDTH'(r_prod);
        end
    end
    assign acc = r_acc;
endmodule

// File: rtl/npu_conv_engine.sv
// npu_conv_engine: memory-mapped convolution engine; port decode, buffers, tap FSM,
// N MAC lanes, result registers and registered read mux.
module npu_conv_engine import npu_pkg::*; #(
    parameter int N          = 10,
    parameter int K_SIZE     = 3,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 3 * DATA_WIDTH,
    parameter int AXI_WIDTH  = 32,
    parameter int ADDR_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_i,
    input  logic [3:0]           wen_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [AXI_WIDTH-1:0] wdata_i,
    output logic [AXI_WIDTH-1:0] rdata_o
);
    localparam int KK = K_SIZE * K_SIZE;
    localparam int NK = N * KK;
    localparam int IB = ibase(N, KK);
    localparam int BB = bbase(N, KK);
    localparam int RB = rbase(N, KK);
    localparam int IW = NK > 1 ? $clog2(NK) : 1;
    localparam int TW = KK > 1 ? $clog2(KK) : 1;
    localparam int LW = N > 1 ? $clog2(N) : 1;

    state_t                      r_state, w_next;
    logic [TW-1:0]               r_tap;
    logic                        r_mode, r_done;
    logic signed [DATA_WIDTH-1:0] r_w [NK];
    logic signed [DATA_WIDTH-1:0] r_in [NK];
    logic signed [DATA_WIDTH-1:0] r_b [KK];
    logic signed [ACC_WIDTH-1:0]  r_res [N];
    logic signed [ACC_WIDTH-1:0]  w_acc [N];
    logic signed [DATA_WIDTH-1:0] w_data;
    logic [AXI_WIDTH-1:0]        w_rdata;
    logic w_wr, w_rd, w_ctrl_wr, w_start, w_clear, w_idle, w_run, w_go, w_clr, w_last, w_unused;
    int   w_a;

    assign w_a       = int'(addr_i);
    assign w_wr      = req_i && |wen_i;
    assign w_rd      = req_i && !(|wen_i);
    assign w_data    = wdata_i[DATA_WIDTH-1:0];
    assign w_ctrl_wr = w_wr && w_a == CTRL_ADDR;
    assign w_start   = w_ctrl_wr && wdata_i[CTRL_START];
    assign w_clear   = w_ctrl_wr && wdata_i[CTRL_CLEAR];
    assign w_idle    = r_state == IDLE;
    assign w_run     = r_state == RUN;
    assign w_last    = r_tap == TW'(KK - 1);
    assign w_go      = w_idle && w_start && !w_clear;
    // Start and clear both zero the lane accumulators; clear also aborts a run.
    assign w_clr     = w_clear || w_go;
    assign w_unused  = ^wdata_i[AXI_WIDTH-1:DATA_WIDTH];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_go ? RUN : IDLE;
            RUN:     w_next = w_clear ? IDLE : (w_last ? DRAIN : RUN);
            DRAIN:   w_next = w_clear ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tap  <= '0;
            r_mode <= 1'b0;
            r_done <= 1'b0;
        end else begin
            if (w_go) r_tap <= '0;
            else if (w_run && !w_last) r_tap <= r_tap + 1'b1;
            if (w_idle && w_ctrl_wr) r_mode <= wdata_i[CTRL_MODE];
            if (w_clr) r_done <= 1'b0;
            else if (r_state == DONE) r_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NK; i++) begin
                r_w[i]  <= '0;
                r_in[i] <= '0;
            end
            for (int i = 0; i < KK; i++) r_b[i] <= '0;
        end else if (w_idle && w_wr) begin
            if (w_a >= WBASE && w_a < IB) r_w[IW'(w_a - WBASE)] <= w_data;
            if (w_a >= IB && w_a < BB)    r_in[IW'(w_a - IB)]   <= w_data;
            if (w_a >= BB && w_a < RB)    r_b[TW'(w_a - BB)]    <= w_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) r_res[i] <= '0;
        end else if (r_state == DONE && !w_clear) begin
            for (int i = 0; i < N; i++) r_res[i] <= w_acc[i];
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        npu_mac_lane #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane (
            .clk   (clk),
            .reset (reset),
            .clr   (w_clr),
            .en    (w_run),
            .a     (r_w[IW'(g * KK + int'(r_tap))]),
            .b     (r_mode ? r_b[r_tap] : r_in[IW'(g * KK + int'(r_tap))]),
            .acc   (w_acc[g])
        );
    end

    always_comb begin
        w_rdata = '0;
        if (w_a == CTRL_ADDR) w_rdata[CTRL_MODE] = r_mode;
        else if (w_a == STATUS_ADDR) begin
            w_rdata[ST_BUSY]     = !w_idle;
            w_rdata[ST_DONE]     = r_done;
            w_rdata[ST_MODE]     = r_mode;
            w_rdata[ST_TAP +: 8] = 8'(r_tap);
        end
        else if (w_a >= WBASE && w_a < IB) w_rdata = AXI_WIDTH'(r_w[IW'(w_a - WBASE)]);
        else if (w_a >= IB && w_a < BB)    w_rdata = AXI_WIDTH'(r_in[IW'(w_a - IB)]);
        else if (w_a >= BB && w_a < RB)    w_rdata = AXI_WIDTH'(r_b[TW'(w_a - BB)]);
        else if (w_a >= RB && w_a < RB + N) w_rdata = AXI_WIDTH'(r_res[LW'(w_a - RB)]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     rdata_o <= '0;
        else if (w_rd) rdata_o <= w_rdata;
    end
endmodule

// File: tb/tb_npu_conv_engine.sv
// tb_npu_conv_engine: directed stimulus pushes expected read data into a queue;
// a monitor pops and compares one cycle after each read is sampled.
module tb_npu_conv_engine;
    localparam int N = 10, KK = 9, WB = 16, IB = 106, BB = 196, RB = 205;

    logic        clk = 1'b0, reset = 1'b1, req_i = 1'b0;
    logic [3:0]  wen_i = '0;
    logic [7:0]  addr_i = '0;
    logic [31:0] wdata_i = '0, rdata_o;
    int          n_cmp = 0, n_bad = 0;

    typedef struct {string nm; logic [31:0] exp; logic [31:0] mask;} exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    npu_conv_engine dut (
        .clk     (clk),
        .reset   (reset),
        .req_i   (req_i),
        .wen_i   (wen_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o)
    );

    logic rd_q;
    always @(posedge clk or posedge reset) begin
        if (reset) rd_q <= 1'b0;
        else       rd_q <= req_i && (wen_i == 4'h0);
    end

    always @(negedge clk) begin
        exp_t e;
        if (rd_q) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_read: got %h, nothing expected", rdata_o);
            end else begin
                e = q.pop_front();
                if ((rdata_o & e.mask) !== (e.exp & e.mask)) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h (mask %h)", e.nm, rdata_o, e.exp, e.mask);
                end
            end
        end
    end

    task automatic wr(input int a, input logic [31:0] d);
        @(negedge clk);
        req_i = 1'b1; wen_i = 4'hf; addr_i = 8'(a); wdata_i = d;
    endtask

    task automatic rd(input int a, input logic [31:0] e, input string nm, input logic [31:0] m = '1);
        @(negedge clk);
        req_i = 1'b1; wen_i = 4'h0; addr_i = 8'(a);
        q.push_back('{nm, e, m});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_i = 1'b0; wen_i = 4'h0;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] e);
        n_cmp++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, e);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_rdata", rdata_o, 32'h0);
        rd(1, 0, "rst_status");
        rd(0, 0, "rst_ctrl");
        rd(WB, 0, "rst_weight");
        rd(RB, 0, "rst_result");

        // per-lane: lane 0 weights 1, inputs 1..9
        for (int t = 0; t < KK; t++) wr(WB + t, 1);
        for (int t = 0; t < KK; t++) wr(IB + t, t + 1);
        rd(WB, 1, "w0_readback");
        idle(2);
        chk("rdata_hold", rdata_o, 32'h1);
        rd(IB + 8, 9, "in_readback");
        wr(0, 1);
        for (int k = 1; k <= 9; k++) rd(1, ((k - 1) << 8) | 1, "run_tap", 32'h0000ff07);
        rd(1, 32'h1, "drain_busy", 32'h7);
        rd(1, 32'h1, "done_state_busy", 32'h7);
        rd(1, 32'h2, "done_at_11", 32'h7);
        for (int i = 0; i < N; i++) rd(RB + i, i == 0 ? 45 : 0, "perlane_result");

        // broadcast: lane i weights i+1, broadcast inputs 2
        for (int i = 0; i < N; i++)
            for (int t = 0; t < KK; t++) wr(WB + i * KK + t, i + 1);
        for (int t = 0; t < KK; t++) wr(BB + t, 2);
        wr(0, 5);
        idle(13);
        rd(1, 32'h6, "bc_status", 32'h7);
        rd(0, 32'h4, "ctrl_mode");
        rd(BB, 2, "bc_readback");
        for (int i = 0; i < N; i++) rd(RB + i, 18 * (i + 1), "bc_result");

        // signed corners on lane 0
        for (int t = 0; t < KK; t++) begin
            wr(WB + t, 32'hffffff80);
            wr(IB + t, 32'hffffff80);
        end
        wr(0, 1);
        idle(13);
        rd(WB, 32'hffffff80, "w_signext");
        rd(RB, 147456, "neg_x_neg");
        rd(RB + 1, 0, "lane1_zero_input");
        for (int t = 0; t < KK; t++) wr(WB + t, 127);
        wr(0, 1);
        idle(13);
        rd(RB, -146304, "pos_x_neg");

        // writes and a second start during busy are ignored
        wr(0, 1);
        wr(WB, 5);
        idle(1);
        wr(0, 1);
        idle(8);
        rd(1, 32'h2, "restart_ignored", 32'h7);
        rd(WB, 127, "busy_wr_ignored");
        rd(RB, -146304, "busy_run_result");

        // abort with clear at cycle 4 keeps the previous result
        for (int t = 0; t < KK; t++) wr(WB + t, 1);
        wr(0, 1);
        idle(3);
        wr(0, 2);
        rd(1, 32'h0, "abort_status", 32'h7);
        rd(RB, -146304, "abort_keeps_result");
        idle(12);
        rd(1, 32'h0, "abort_never_done", 32'h7);

        // async reset mid-run
        wr(0, 1);
        rd(RB, -146304, "busy_read");
        idle(1);
        #2 reset = 1'b1;
        #1 chk("async_reset_rdata", rdata_o, 32'h0);
        #1 reset = 1'b0;
        rd(1, 0, "post_rst_status");
        rd(RB, 0, "post_rst_result");
        rd(WB, 0, "post_rst_weight");
        for (int t = 0; t < KK; t++) begin
            wr(WB + t, 3);
            wr(IB + t, t + 1);
        end
        wr(0, 1);
        idle(13);
        rd(RB, 135, "post_rst_run");
        rd(RB + 1, 0, "post_rst_lane1");
        idle(2);

        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_reads: got %0d outstanding expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
